// File: rtl/message_printer_pkg.sv
// Shared constants for the message printer: parameter defaults
// and the 2-bit FSM state encoding.
package message_printer_pkg;

  localparam int          MSG_LEN_DEF  = 23;
  localparam int          ADDR_W_DEF   = 5;
  localparam logic [7:0]  TRIGGER_DEF  = 8'h68;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/message_printer.sv
// Streams a ROM-resident message to a UART transmitter, one byte
// per FETCH/SEND/GAP round, when the trigger byte is received.
module message_printer
  import message_printer_pkg::*;
#(
  parameter int         MSG_LEN      = MSG_LEN_DEF,
  parameter int         ADDR_W       = ADDR_W_DEF,
  parameter logic [7:0] TRIGGER_CHAR = TRIGGER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_block,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [7:0]        tx_q,    tx_d;
  logic              ntx_q,   ntx_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic trig;
  // A trigger landing in the done cycle is dropped on purpose.
  assign trig = new_rx_data && (rx_data == TRIGGER_CHAR) && !done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    ntx_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_FETCH;
          addr_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_block) begin
          tx_d    = rom_data;
          ntx_d   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (addr_q == LAST) begin
          state_d = S_IDLE;
          addr_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      tx_q    <= '0;
      ntx_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      ntx_q   <= ntx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr    = addr_q;
  assign tx_data     = tx_q;
  assign new_tx_data = ntx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_message_printer.sv
// Scoreboard bench for message_printer: ROM model, tx_block model
// and one task per scenario.
module tb_message_printer;
  import message_printer_pkg::*;

  localparam int N  = MSG_LEN_DEF;
  localparam int AW = ADDR_W_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          new_rx_data;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    tx_data;
  logic          new_tx_data;
  logic          tx_block;
  logic          busy;
  logic          done;

  message_printer #(
    .MSG_LEN(N), .ADDR_W(AW), .TRIGGER_CHAR(TRIGGER_DEF)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .new_rx_data(new_rx_data),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data),
    .tx_block(tx_block), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:(1<<AW)-1];
  string      msg = "Hello World, Vinayak!\n\r";

  always @(posedge clk) rom_data <= rom[rom_addr];

  logic [7:0] exp_q [$];
  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int strobes  = 0;
  int dones    = 0;
  int last_cyc = -1;
  int exp_gap  = 3;
  bit blk_mode = 1'b0;
  logic [7:0] mon_e;

  // Monitor: pops the scoreboard on every strobe and checks spacing
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst === 1'b1) last_cyc = -1;
      if (done === 1'b1) begin
        dones++;
        last_cyc = -1;
      end
      if (new_tx_data === 1'b1) begin
        strobes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got tx_data=%h, required no strobe", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (tx_data !== mon_e) begin
            errors++;
            $display("FAIL strobe_data: got %h, required %h", tx_data, mon_e);
          end
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != exp_gap) begin
            errors++;
            $display("FAIL strobe_gap: got %0d, required %0d", cyc - last_cyc, exp_gap);
          end
        end
        last_cyc = cyc;
      end
    end
  end

  // Transmitter model: stays busy 10 cycles after each strobe
  initial begin
    tx_block = 1'b0;
    forever begin
      @(negedge clk);
      if (blk_mode && new_tx_data === 1'b1) begin
        tx_block = 1'b1;
        repeat (10) @(negedge clk);
        tx_block = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_msg();
    for (int i = 0; i < N; i++) exp_q.push_back(rom[i]);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
    rx_data     = 8'h00;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobes(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (strobes >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rom_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h, required 0", rom_addr); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
    checks++;
    if (new_tx_data !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b, required 0", new_tx_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int d0, s0, drop;
    bit ok;
    d0 = dones; s0 = strobes; drop = 0; ok = 1'b0;
    push_msg();
    send_rx("h");
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b, required 1", busy); end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
      if (busy !== 1'b1) drop++;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done, required done"); end
    checks++;
    if (drop != 0) begin errors++; $display("FAIL basic_busy_hold: got %0d low cycles, required 0", drop); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b, required 0", busy); end
    checks++;
    if (rom_addr !== '0) begin errors++; $display("FAIL basic_addr_end: got %h, required 0", rom_addr); end
    repeat (5) @(negedge clk);
    checks++;
    if (dones - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d, required 1", dones - d0); end
    checks++;
    if (strobes - s0 != N) begin errors++; $display("FAIL basic_strobe_count: got %0d, required %0d", strobes - s0, N); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_ignore();
    int s0, bad;
    s0 = strobes; bad = 0;
    send_rx("x");
    send_rx("H");
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ignore_busy: got %0d busy cycles, required 0", bad); end
    checks++;
    if (strobes != s0) begin errors++; $display("FAIL ignore_strobes: got %0d, required 0", strobes - s0); end
  endtask

  task automatic test_block();
    int d0;
    bit ok;
    d0 = dones;
    blk_mode = 1'b1;
    exp_gap  = 11;
    push_msg();
    send_rx("h");
    wait_done(N * 12 + 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL block_done_timeout: got no done, required done"); end
    repeat (14) @(negedge clk);
    blk_mode = 1'b0;
    exp_gap  = 3;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL block_left: got %0d, required 0", exp_q.size()); end
    checks++;
    if (dones - d0 != 1) begin errors++; $display("FAIL block_done_count: got %0d, required 1", dones - d0); end
  endtask

  task automatic test_retrigger();
    int d0, s0;
    bit ok;
    d0 = dones; s0 = strobes;
    push_msg();
    send_rx("h");
    wait_strobes(s0 + 5, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL retrig_progress: got %0d strobes, required 5", strobes - s0); end
    send_rx("h");
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL retrig_done_timeout: got no done, required done"); end
    repeat (30) @(negedge clk);
    checks++;
    if (dones - d0 != 1) begin errors++; $display("FAIL retrig_done_count: got %0d, required 1", dones - d0); end
    checks++;
    if (strobes - s0 != N) begin errors++; $display("FAIL retrig_strobes: got %0d, required %0d", strobes - s0, N); end
  endtask

  task automatic test_reset_mid();
    int s0, s1;
    bit ok;
    s0 = strobes;
    push_msg();
    send_rx("h");
    wait_strobes(s0 + 10, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_progress: got %0d strobes, required 10", strobes - s0); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({new_tx_data, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_flags: got strobe/busy/done=%b, required 000", {new_tx_data, busy, done});
    end
    checks++;
    if (rom_addr !== '0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rmid_regs: got addr=%h tx=%h, required 0/00", rom_addr, tx_data);
    end
    s1 = strobes;
    rst = 1'b0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    checks++;
    if (strobes != s1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_quiet: got %0d strobes busy=%b, required 0/0", strobes - s1, busy);
    end
    s1 = strobes;
    push_msg();
    send_rx("h");
    wait_done(200, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || strobes - s1 != N) begin
      errors++;
      $display("FAIL rmid_restart: got %0d strobes, required %0d", strobes - s1, N);
    end
  endtask

  task automatic test_done_cycle();
    int d0, s0;
    bit ok;
    d0 = dones; s0 = strobes;
    push_msg();
    send_rx("h");
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dcyc_first_timeout: got no done, required done"); end
    rx_data     = "h";
    new_rx_data = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL dcyc_ignored: got busy=%b, required 0", busy); end
    push_msg();
    @(negedge clk);
    new_rx_data = 1'b0;
    rx_data     = 8'h00;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL dcyc_started: got busy=%b, required 1", busy); end
    wait_done(200, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || dones - d0 != 2) begin errors++; $display("FAIL dcyc_done_count: got %0d, required 2", dones - d0); end
    checks++;
    if (strobes - s0 != 2 * N) begin errors++; $display("FAIL dcyc_strobes: got %0d, required %0d", strobes - s0, 2 * N); end
  endtask

  initial begin
    rst         = 1'b1;
    rx_data     = 8'h00;
    new_rx_data = 1'b0;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'h00;
    for (int i = 0; i < N; i++) rom[i] = msg[i];
    test_reset();
    test_basic();
    test_ignore();
    test_block();
    test_retrigger();
    test_reset_mid();
    test_done_cycle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_left: got %0d, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
